bit_serial_add_ctrl: RTL and testbench

BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

---
 rtl/bit_serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder/subtractor controller.
// One full-adder cell processes one operand bit per RUN cycle, LSB first.
// Operands are captured on the start edge, so later input changes cannot
// disturb the operation. The result registers only change on completion.
module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic [WIDTH-1:0] sum_q;
    logic            cout_q;
    logic            ovf_q;

    // Working shift registers: operands shift right, result fills from the top.
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;

    logic             fa_sum_d;
    logic             fa_carry_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit_d;
    logic             accept_d;

    // Single full-adder cell on the current LSBs plus the carry register.
    always_comb begin
        fa_sum_d   = opa_q[0] ^ opb_q[0] ^ carry_q;
        fa_carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        res_d      = {fa_sum_d, res_q[WIDTH-1:1]};
        last_bit_d = (cnt_q == LAST);
        accept_d   = (state_q == S_IDLE) && start;
    end

    // Control FSM with registered busy/done and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        // Subtraction is a + ~b + 1, so the carry seeds to 1.
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    carry_q <= fa_carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= fa_carry_d;
                        // Carry into the MSB differs from carry out of it.
                        ovf_q   <= carry_q ^ fa_carry_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and bit shifting; contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            opa_q <= a;
            opb_q <= sub ? ~b : b;
            res_q <= '0;
        end else if (state_q == S_RUN) begin
            opa_q <= {1'b0, opa_q[WIDTH-1:1]};
            opb_q <= {1'b0, opb_q[WIDTH-1:1]};
            res_q <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl (WIDTH = 8).
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                            input logic tsub, input logic tcin);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ci;
        logic         ov;
        bb   = tsub ? ~tb : tb;
        ci   = tsub ? 1'b1 : tcin;
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov   = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Behavioural model: an accepted operation occupies W+2 edges; result
    // appears W edges after acceptance; start is only seen when idle.
    logic         m_active = 1'b0;
    int           m_k      = 0;
    logic [W+1:0] m_pend   = '0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;
    logic         m_ovf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_active) begin
            m_k <= m_k + 1;
            if (m_k == W - 1) begin
                m_sum  <= m_pend[W-1:0];
                m_cout <= m_pend[W];
                m_ovf  <= m_pend[W+1];
            end
            if (m_k == W) m_active <= 1'b0;
        end else if (start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_pend   <= ref_op(a, b, sub, cin);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", busy, m_active && (m_k < W));
        chk("done", done, m_active && (m_k == W));
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("ovf", ovf, m_ovf);
        chk("busy_done_excl", busy & done, 1'b0);
    end

    // Present a start for exactly one edge, then scramble the inputs.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tsub, input logic tcin);
        @(negedge clk);
        a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = tb ^ 8'h5A; sub = ~tsub; cin = ~tcin;
    endtask

    task automatic wait_done(input bit scramble, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (scramble) begin
                a = W'($urandom); b = W'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
        end
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] es,
                                input logic ec, input logic eo, input int n, input int en);
        chk({nm, "_latency"}, n, en);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        chk({nm, "_model_sum"}, m_sum, es);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tcin,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        start_op(ta, tb, tsub, tcin);
        wait_done(1'b0, n);
        check_result(nm, es, ec, eo, n, W);
    endtask

    initial begin
        int n;
        int cyc;
        int nd;
        int d[3];
        logic [W-1:0] ra, rb;
        logic rs, rc;
        logic [W+1:0] rexp;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_sum", sum, 8'h00);

        // First start accepted on the first edge after reset release.
        rst = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done(1'b0, n);
        check_result("ff_plus_1", 8'h00, 1'b1, 1'b0, n, W);

        run_op("7f_plus_1",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("80_plus_ff",  8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_op("5_minus_3",   8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("3_minus_5",   8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("cin_add",     8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);

        // Second start mid-operation must be ignored.
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, n);
        check_result("ignore_start", 8'h46, 1'b0, 1'b0, n, W - 3);

        // Asynchronous reset in the middle of an operation.
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_sum", sum, 8'h00);
        chk("async_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op("after_reset", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

        // Start held high: one operation every W+2 cycles.
        @(negedge clk);
        a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
        cyc = 0; nd = 0; d = '{0, 0, 0};
        while (nd < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                d[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        chk("b2b_count", nd, 3);
        chk("b2b_period0", d[1] - d[0], W + 2);
        chk("b2b_period1", d[2] - d[1], W + 2);
        chk("b2b_sum", sum, 8'h03);
        repeat (3) @(negedge clk);

        // Random regression with inputs scrambled during each operation.
        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            rexp = ref_op(ra, rb, rs, rc);
            start_op(ra, rb, rs, rc);
            wait_done(1'b1, n);
            chk("rand_latency", n, W);
            chk("rand_sum", sum, rexp[W-1:0]);
            chk("rand_cout", cout, rexp[W]);
            chk("rand_ovf", ovf, rexp[W+1]);
            a = '0; b = '0; sub = 1'b0; cin = 1'b0;
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
